// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
//   Shared definitions for the systolic-array sequencer.
//   - state_t and the four sequencer state encodings
//   - PE mode encodings (which direction the partial sums accumulate)
//   - max_u: small constant helper used to derive the feed skew
// ---------------------------------------------------------------------------
package sa_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FEED  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // 0: accumulate towards east, pass south; 1: accumulate south, pass east
  localparam logic MODE_EAST  = 1'b0;
  localparam logic MODE_SOUTH = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// ---------------------------------------------------------------------------
// sa_skew_gen
//   Combinational lane-valid generator for one edge of the array. Lane i is
//   valid while the feed index lies in [i, i + k_len), which produces the
//   diagonal wavefront a systolic array needs.
// Ports
//   feed_cnt_i  in  CW     current (next-state) feed index
//   k_len_i     in  CW     operand stream length per lane
//   vld_o       out LANES  per-lane valid
// ---------------------------------------------------------------------------
module sa_skew_gen #(
  parameter int LANES = 4,
  parameter int CW    = 9
) (
  input  logic [CW-1:0]    feed_cnt_i,
  input  logic [CW-1:0]    k_len_i,
  output logic [LANES-1:0] vld_o
);

  // One extra bit so lane + k_len never wraps
  logic [CW:0] cnt_x;
  assign cnt_x = {1'b0, feed_cnt_i};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [CW:0] LANE = (CW+1)'(gi);
      logic [CW:0] end_x;
      assign end_x     = LANE + {1'b0, k_len_i};
      assign vld_o[gi] = (cnt_x >= LANE) && (cnt_x < end_x);
    end
  endgenerate

endmodule

// File: rtl/sa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sa_seq_ctrl
//   Job sequencer for a ROWS x COLS systolic array. A start in IDLE latches
//   mode/bypass/k_len, then FEED streams skewed lane valids for
//   F = k_len + SKEW - 1 cycles, DRAIN keeps the PEs enabled for
//   D = ROWS + COLS + PE_LAT cycles to flush the pipeline, and DONE pulses
//   done for one cycle.
// Ports
//   clk         in   1      clock, posedge
//   sys_rst_n   in   1      synchronous active-low reset
//   start       in   1      command strobe (honoured only in IDLE)
//   cmd_mode    in   1      accumulate direction, latched on start
//   cmd_bypass  in   1      bypass flag, latched on start
//   k_len       in   CNT_W  operands per lane (0 = empty job)
//   stall       in   1      back-pressure; freezes the array and the sequencer
//   busy        out  1      high in FEED and DRAIN
//   done        out  1      one-cycle completion pulse
//   pe_en       out  1      array-wide PE enable
//   pe_mode     out  1      latched cmd_mode
//   pe_bypass   out  1      latched cmd_bypass
//   west_vld    out  ROWS   west feeder read enables
//   north_vld   out  COLS   north feeder read enables
//   feed_cnt    out  CNT_W  FEED-phase index (lane i reads element feed_cnt-i)
// ---------------------------------------------------------------------------
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CNT_W  = 8,
  parameter int PE_LAT = 2
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             cmd_mode,
  input  logic             cmd_bypass,
  input  logic [CNT_W-1:0] k_len,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             pe_en,
  output logic             pe_mode,
  output logic             pe_bypass,
  output logic [ROWS-1:0]  west_vld,
  output logic [COLS-1:0]  north_vld,
  output logic [CNT_W-1:0] feed_cnt
);

  // Internal counters carry one extra bit so k_len + SKEW - 1 never wraps
  localparam int IW = CNT_W + 1;
  localparam int SKEW = int'(max_u(ROWS, COLS));
  localparam logic [IW-1:0] SKEW_W = IW'(SKEW);
  localparam logic [IW-1:0] D_LAST = IW'(ROWS + COLS + PE_LAT - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   feed_cnt_q, feed_cnt_d;
  logic [IW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic            mode_q, mode_d;
  logic            bypass_q, bypass_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pe_en_q, pe_en_d;
  logic [ROWS-1:0] west_q, west_d;
  logic [COLS-1:0] north_q, north_d;

  logic [ROWS-1:0] west_cmp;
  logic [COLS-1:0] north_cmp;
  logic [IW-1:0]   f_last;

  // Index of the final FEED cycle: F - 1 = k_len + SKEW - 2 (k_len >= 1 here)
  assign f_last = {1'b0, k_q} + SKEW_W - IW'(2);

  // ---------------- state / output register ----------------
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      k_q         <= '0;
      mode_q      <= MODE_EAST;
      bypass_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_en_q     <= 1'b0;
      west_q      <= '0;
      north_q     <= '0;
    end else begin
      state_q     <= state_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      bypass_q    <= bypass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pe_en_q     <= pe_en_d;
      west_q      <= west_d;
      north_q     <= north_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d     = state_q;
    feed_cnt_d  = feed_cnt_q;
    drain_cnt_d = drain_cnt_q;
    k_d         = k_q;
    mode_d      = mode_q;
    bypass_d    = bypass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d         = k_len;
          mode_d      = cmd_mode;
          bypass_d    = cmd_bypass;
          feed_cnt_d  = '0;
          drain_cnt_d = '0;
          state_d     = (k_len == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (!stall) begin
          if (feed_cnt_q == f_last) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end else begin
            feed_cnt_d = feed_cnt_q + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_cnt_q == D_LAST) begin
            state_d = S_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + IW'(1);
          end
        end
      end
      default: begin
        // S_DONE: always a single cycle, start is not looked at here
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane valids are evaluated on the next-state counter so they land in the
  // output registers together with the state they belong to.
  sa_skew_gen #(.LANES(ROWS), .CW(IW)) u_skew_west (
    .feed_cnt_i (feed_cnt_d),
    .k_len_i    ({1'b0, k_d}),
    .vld_o      (west_cmp)
  );

  sa_skew_gen #(.LANES(COLS), .CW(IW)) u_skew_north (
    .feed_cnt_i (feed_cnt_d),
    .k_len_i    ({1'b0, k_d}),
    .vld_o      (north_cmp)
  );

  // ---------------- output logic (from next state) ----------------
  always_comb begin
    busy_d  = (state_d == S_FEED) || (state_d == S_DRAIN);
    pe_en_d = busy_d;
    done_d  = (state_d == S_DONE);
    west_d  = (state_d == S_FEED) ? west_cmp  : '0;
    north_d = (state_d == S_FEED) ? north_cmp : '0;
  end

  // stall masks the enables in the same cycle it is raised so that no PE
  // advances and no feeder pops while back-pressure is present. The enables
  // are only ever set in FEED/DRAIN, so stall has no effect elsewhere.
  assign busy      = busy_q;
  assign done      = done_q;
  assign pe_en     = pe_en_q & ~stall;
  assign west_vld  = west_q  & {ROWS{~stall}};
  assign north_vld = north_q & {COLS{~stall}};
  assign pe_mode   = mode_q;
  assign pe_bypass = bypass_q;
  assign feed_cnt  = feed_cnt_q[CNT_W-1:0];

endmodule
